// File: rtl/vec_pkg.sv
// Shared definitions for the vector execution path: op codes (shared with
// decode), sequencer state encoding and default vector geometry.
package vec_pkg;

    localparam int VEC_LANES  = 4;
    localparam int VEC_LANE_W = 32;

    typedef logic [3:0] vec_op_t;

    localparam vec_op_t OP_VADD   = 4'b1000;
    localparam vec_op_t OP_VSUB   = 4'b1001;
    localparam vec_op_t OP_VAND   = 4'b1010;
    localparam vec_op_t OP_VORR   = 4'b1011;
    localparam vec_op_t OP_VADDFP = 4'b1101;
    localparam vec_op_t OP_VXOR   = 4'b1111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INT  = 2'd1;
    localparam logic [1:0] ST_FP   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic is_int_op(input vec_op_t op);
        return (op == OP_VADD) || (op == OP_VSUB) || (op == OP_VAND) ||
               (op == OP_VORR) || (op == OP_VXOR);
    endfunction

    function automatic logic is_fp_op(input vec_op_t op);
        return op == OP_VADDFP;
    endfunction

endpackage

// File: rtl/vec_exec_seq_if.sv
// Request/acknowledge link between the vector sequencer and the external FP adder.
// fp_req rises with fp_a/fp_b and holds them stable until fp_ack; the lane transfers on the
// edge where fp_req && fp_ack, fp_sum is valid only then, and fp_ack while fp_req is low is ignored.
interface vec_exec_seq_if #(
    parameter int LANE_W = 32
) ();

    logic              fp_req;
    logic [LANE_W-1:0] fp_a;
    logic [LANE_W-1:0] fp_b;
    logic              fp_ack;
    logic [LANE_W-1:0] fp_sum;

    modport master (
        output fp_req,
        output fp_a,
        output fp_b,
        input  fp_ack,
        input  fp_sum
    );

    modport slave (
        input  fp_req,
        input  fp_a,
        input  fp_b,
        output fp_ack,
        output fp_sum
    );

endinterface

// File: rtl/vec_lane_alu.sv
// Single-lane integer ALU shared by all lanes of the sequencer; modulo 2^LANE_W, no flags.
module vec_lane_alu
    import vec_pkg::*;
#(
    parameter int LANE_W = VEC_LANE_W
) (
    input  vec_op_t           op,
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_VADD: y = a + b;
            OP_VSUB: y = a - b;
            OP_VAND: y = a & b;
            OP_VORR: y = a | b;
            OP_VXOR: y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/vec_exec_seq.sv
// Multi-cycle vector sequencer: latches operands on Start, walks lanes through the
// shared lane ALU (integer ops) or the external FP adder (VADDFP), then pulses Done.
module vec_exec_seq
    import vec_pkg::*;
#(
    parameter int LANES  = VEC_LANES,
    parameter int LANE_W = VEC_LANE_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    Start,
    input  logic [3:0]              ALUControl,
    input  logic                    BcastB,
    input  logic [LANES*LANE_W-1:0] SrcA,
    input  logic [LANES*LANE_W-1:0] SrcB,
    output logic [LANES*LANE_W-1:0] Result,
    output logic                    Busy,
    output logic                    Done,
    output logic                    IllegalOp,
    output logic [1:0]              dbg_state,
    vec_exec_seq_if.master          fp
);

    localparam int              CW        = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0]   LAST_LANE = CW'(LANES - 1);

    logic [1:0]              state;
    logic [CW-1:0]           lane_cnt;
    vec_op_t                 op_q;
    logic [LANES*LANE_W-1:0] op_a;
    logic [LANES*LANE_W-1:0] op_b;
    logic [LANES*LANE_W-1:0] result_q;
    logic                    illegal_q;
    int                      lane_base;
    logic [LANE_W-1:0]       lane_y;

    assign lane_base = int'(lane_cnt) * LANE_W;

    vec_lane_alu #(.LANE_W(LANE_W)) u_lane_alu (
        .op (op_q),
        .a  (op_a[lane_base +: LANE_W]),
        .b  (op_b[lane_base +: LANE_W]),
        .y  (lane_y)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            lane_cnt  <= '0;
            op_q      <= '0;
            op_a      <= '0;
            op_b      <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
            fp.fp_req <= 1'b0;
            fp.fp_a   <= '0;
            fp.fp_b   <= '0;
        end else begin
            illegal_q <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    state    <= ST_IDLE;
                    lane_cnt <= '0;
                    if (Start) begin
                        if (is_int_op(ALUControl) || is_fp_op(ALUControl)) begin
                            op_q <= ALUControl;
                            op_a <= SrcA;
                            op_b <= BcastB ? {LANES{SrcB[LANE_W-1:0]}} : SrcB;
                        end
                        if (is_int_op(ALUControl)) begin
                            state <= ST_INT;
                        end else if (is_fp_op(ALUControl)) begin
                            // Lane 0 of SrcB is the same with or without broadcast.
                            state     <= ST_FP;
                            fp.fp_req <= 1'b1;
                            fp.fp_a   <= SrcA[LANE_W-1:0];
                            fp.fp_b   <= SrcB[LANE_W-1:0];
                        end else begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                ST_INT: begin
                    result_q[lane_base +: LANE_W] <= lane_y;
                    if (lane_cnt == LAST_LANE) begin
                        lane_cnt <= '0;
                        state    <= ST_DONE;
                    end else begin
                        lane_cnt <= lane_cnt + 1'b1;
                    end
                end
                ST_FP: begin
                    if (fp.fp_req) begin
                        if (fp.fp_ack) begin
                            result_q[lane_base +: LANE_W] <= fp.fp_sum;
                            fp.fp_req <= 1'b0;
                            if (lane_cnt == LAST_LANE) begin
                                lane_cnt <= '0;
                                state    <= ST_DONE;
                            end else begin
                                lane_cnt <= lane_cnt + 1'b1;
                            end
                        end
                    end else begin
                        // Gap cycle after an ack: present the next lane's operands.
                        fp.fp_req <= 1'b1;
                        fp.fp_a   <= op_a[lane_base +: LANE_W];
                        fp.fp_b   <= op_b[lane_base +: LANE_W];
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    lane_cnt <= '0;
                end
            endcase
        end
    end

    assign Result    = result_q;
    assign Busy      = (state == ST_INT) || (state == ST_FP);
    assign Done      = (state == ST_DONE);
    assign IllegalOp = illegal_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_vec_exec_seq.sv
// Directed bench for vec_exec_seq: integer ops, broadcast, FP handshake with
// variable ack delays, illegal code, retrigger/back-to-back and mid-operation reset.
module tb_vec_exec_seq;
  import vec_pkg::*;

  localparam int LANES  = 4;
  localparam int LANE_W = 32;
  localparam int VW     = LANES * LANE_W;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    alu_control = 4'd0;
  logic          bcast_b = 1'b0;
  logic [VW-1:0] src_a = '0;
  logic [VW-1:0] src_b = '0;
  logic [VW-1:0] result;
  logic          busy;
  logic          done;
  logic          illegal_op;
  logic [1:0]    dbg_state;

  vec_exec_seq_if #(.LANE_W(LANE_W)) fp_if ();

  vec_exec_seq #(.LANES(LANES), .LANE_W(LANE_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .Start      (start),
    .ALUControl (alu_control),
    .BcastB     (bcast_b),
    .SrcA       (src_a),
    .SrcB       (src_b),
    .Result     (result),
    .Busy       (busy),
    .Done       (done),
    .IllegalOp  (illegal_op),
    .dbg_state  (dbg_state),
    .fp         (fp_if)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int t0 = 0;
  int n_cmp = 0;
  int n_err = 0;
  logic [VW-1:0] exp_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: present a Start for one edge; returns in cycle 1 of the operation
  task automatic issue(input logic [3:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                       input logic bc);
    start = 1'b1;
    alu_control = op;
    src_a = a;
    src_b = b;
    bcast_b = bc;
    t0 = cyc;
    step();
    start = 1'b0;
    src_a = {LANES{32'h5A5A_A5A5}};
    src_b = {LANES{32'hC3C3_3C3C}};
    alu_control = OP_VADD;
    bcast_b = 1'b0;
  endtask

  task automatic expect_done(input string tag);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy_low"}, busy, 1'b0);
    if (exp_q.size() == 0) check({tag, "_sb_empty"}, 1'b0, 1'b1);
    else check({tag, "_result"}, result, exp_q.pop_front());
  endtask

  // cycles 1..LANES must be busy without Done; Done in cycle LANES+1
  task automatic run_int(input string tag, input logic chk_partial, input logic [VW-1:0] partial);
    for (int k = 1; k <= LANES; k++) begin
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_done_low"}, done, 1'b0);
      if (chk_partial && k == 2) check({tag, "_partial"}, result, partial);
      step();
    end
    check({tag, "_latency"}, cyc - t0, LANES + 1);
    expect_done(tag);
  endtask

  // FP adder model for one lane: wait for fp_req, hold ack off for dly cycles, then ack
  task automatic fp_lane(input int k, input int dly, input logic [31:0] ea, input logic [31:0] eb,
                         input logic [31:0] sum);
    int w;
    w = 0;
    while (fp_if.fp_req !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    check("fp_req_gap", w, (k == 0) ? 0 : 1);
    check("fp_a", fp_if.fp_a, ea);
    check("fp_b", fp_if.fp_b, eb);
    for (int d = 0; d < dly; d++) begin
      step();
      check("fp_hold", {fp_if.fp_req, fp_if.fp_a, fp_if.fp_b}, {1'b1, ea, eb});
    end
    fp_if.fp_ack = 1'b1;
    fp_if.fp_sum = sum;
    step();
    fp_if.fp_ack = 1'b0;
    fp_if.fp_sum = '0;
    check("fp_req_drop", fp_if.fp_req, 1'b0);
  endtask

  initial begin
    fp_if.fp_ack = 1'b0;
    fp_if.fp_sum = '0;

    // reset values
    step();
    step();
    check("rst_result", result, '0);
    check("rst_flags", {busy, done, illegal_op}, 3'b000);
    check("rst_fp", {fp_if.fp_req, fp_if.fp_a, fp_if.fp_b}, '0);
    check("rst_state", dbg_state, ST_IDLE);
    reset = 1'b1;
    step();

    // VADD: lane 3 wraps to 0 without carrying into a neighbour
    exp_q.push_back({32'd0, 32'd4, 32'd3, 32'd2});
    issue(OP_VADD, {32'hFFFF_FFFF, 32'd3, 32'd2, 32'd1}, {32'd1, 32'd1, 32'd1, 32'd1}, 1'b0);
    run_int("vadd", 1'b1, {32'd0, 32'd0, 32'd0, 32'd2});
    step();
    check("vadd_idle", {busy, done}, 2'b00);
    check("vadd_hold", result, {32'd0, 32'd4, 32'd3, 32'd2});

    // VSUB with broadcast lane 0 of SrcB
    exp_q.push_back({32'd2, 32'hFFFF_FFFB, 32'd0, 32'd5});
    issue(OP_VSUB, {32'd7, 32'd0, 32'd5, 32'd10}, {32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D, 32'd5}, 1'b1);
    run_int("vsub_bc", 1'b0, '0);
    step();

    // illegal code: pulse only, result untouched
    issue(4'b0100, {LANES{32'h1111_1111}}, {LANES{32'h2222_2222}}, 1'b0);
    check("ill_pulse", illegal_op, 1'b1);
    check("ill_quiet", {busy, done, fp_if.fp_req}, 3'b000);
    check("ill_result", result, {32'd2, 32'hFFFF_FFFB, 32'd0, 32'd5});
    check("ill_state", dbg_state, ST_IDLE);
    step();
    check("ill_one_cycle", illegal_op, 1'b0);
    check("ill_result2", result, {32'd2, 32'hFFFF_FFFB, 32'd0, 32'd5});

    // VXOR with a retrigger in cycle 2, then back-to-back VAND from the DONE cycle
    exp_q.push_back({32'hFF00_00FF, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    issue(OP_VXOR, {32'hFFFF_0000, 32'h1234_5678, 32'hAAAA_AAAA, 32'h0F0F_0F0F},
          {32'h00FF_00FF, 32'h1234_5678, 32'h5555_5555, 32'hF0F0_F0F0}, 1'b0);
    step();
    start = 1'b1;
    alu_control = OP_VORR;
    step();
    start = 1'b0;
    check("retrig_busy3", busy, 1'b1);
    step();
    check("retrig_busy4", busy, 1'b1);
    step();
    check("vxor_latency", cyc - t0, LANES + 1);
    expect_done("vxor");
    exp_q.push_back({32'hF000_F000, 32'h0000_FFFF, 32'h0000_5678, 32'h8000_0001});
    issue(OP_VAND, {32'hF0F0_F0F0, 32'h0000_FFFF, 32'h1234_5678, 32'hFFFF_FFFF},
          {32'hFF00_FF00, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'h8000_0001}, 1'b0);
    run_int("b2b_vand", 1'b0, '0);
    step();

    // VADDFP with ack delays 0,2,1,3
    exp_q.push_back({32'h5000_0003, 32'h5000_0002, 32'h5000_0001, 32'h5000_0000});
    issue(OP_VADDFP, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 1'b0);
    check("fp_busy", busy, 1'b1);
    fp_lane(0, 0, 32'hA0, 32'hB0, 32'h5000_0000);
    check("fp_gap_busy", {busy, done}, 2'b10);
    fp_lane(1, 2, 32'hA1, 32'hB1, 32'h5000_0001);
    fp_lane(2, 1, 32'hA2, 32'hB2, 32'h5000_0002);
    fp_lane(3, 3, 32'hA3, 32'hB3, 32'h5000_0003);
    check("fp_latency", cyc - t0, 14);
    expect_done("vaddfp");
    step();

    // reset during FP lane 2, then a stray ack, then a normal VAND
    exp_q.push_back('0);
    issue(OP_VADDFP, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 1'b0);
    fp_lane(0, 0, 32'hC0, 32'hD0, 32'h6000_0000);
    fp_lane(1, 0, 32'hC1, 32'hD1, 32'h6000_0001);
    step();
    check("rst_mid_req", fp_if.fp_req, 1'b1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    exp_q.delete();
    check("rst_mid_fp_req", fp_if.fp_req, 1'b0);
    check("rst_mid_busy", {busy, done}, 2'b00);
    check("rst_mid_result", result, '0);
    check("rst_mid_state", dbg_state, ST_IDLE);
    fp_if.fp_ack = 1'b1;
    fp_if.fp_sum = 32'hBAD0_BAD0;
    step();
    fp_if.fp_ack = 1'b0;
    fp_if.fp_sum = '0;
    step();
    check("stray_ack_result", result, '0);
    check("stray_ack_quiet", {busy, done, fp_if.fp_req}, 3'b000);
    exp_q.push_back({32'h1, 32'h2, 32'h6, 32'h8});
    issue(OP_VAND, {32'h1, 32'h3, 32'h7, 32'hF}, {32'hF, 32'hE, 32'h6, 32'h8}, 1'b0);
    run_int("post_rst_vand", 1'b0, '0);
    step();

    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
